ctrl_pipe_hazard: RTL and testbench
===================================

CTRL_PIPE_HAZARD -- requirements
Module: ctrl_pipe_hazard

Interface
REQ-001 Parameter: CNT_W, default 16, width of bubble counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_ctrl  in  11  decoded control bundle from ID: [10]RegDst [9]Branch_Beq [8]Branch_Bne [7]MemRead [6]MemtoReg [5:4]ALUOp [3]MemWrite [2]ALUSrc [1]RegWrite [0]jump.
REQ-006 id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID.
REQ-007 ex_zero  in  1  ALU zero flag for the instruction currently in EX.
REQ-008 ex_ctrl  out  11  registered ID/EX control, same bit map as id_ctrl.
REQ-009 ex_rt, ex_rd  out  5 each  registered ID/EX register fields.
REQ-010 mem_ctrl  out  4  registered EX/MEM control: [3]MemRead [2]MemWrite [1]MemtoReg [0]RegWrite.
REQ-011 mem_dest  out  5  registered EX/MEM destination register.
REQ-012 wb_ctrl  out  2  registered MEM/WB control: [1]MemtoReg [0]RegWrite.
REQ-013 wb_dest  out  5  registered MEM/WB destination register.
REQ-014 pc_write, ifid_write, ifid_flush  out  1 each  fetch-side steering, combinational.
REQ-015 branch_taken  out  1  combinational branch resolution from EX.
REQ-016 bubble_cnt  out  CNT_W  registered count of inserted bubbles.

Function
REQ-017 branch_taken SHALL equal (ex_ctrl[9] & ex_zero) | (ex_ctrl[8] & ~ex_zero).
REQ-018 load_use SHALL be 1 when ex_ctrl[7]=1, ex_rt!=0, and (ex_rt==id_rs, or ex_rt==id_rt with id_ctrl[2]=0 or id_ctrl[3]=1).
REQ-019 stall SHALL equal load_use & ~branch_taken; taken branch has priority over stall.
REQ-020 pc_write SHALL be ~stall; ifid_write SHALL be ~stall.
REQ-021 ifid_flush SHALL be branch_taken | (id_ctrl[0] & ~stall); a stalled jump is re-presented and flushes on the cycle it proceeds.
REQ-022 ID/EX: on edge with stall=1 or branch_taken=1, ex_ctrl/ex_rt/ex_rd SHALL load 0 (bubble); otherwise they SHALL load id_ctrl/id_rt/id_rd.
REQ-023 EX/MEM SHALL load every cycle: mem_ctrl = {ex_ctrl[7], ex_ctrl[3], ex_ctrl[6], ex_ctrl[1]}, mem_dest = ex_ctrl[10] ? ex_rd : ex_rt.
REQ-024 MEM/WB SHALL load every cycle: wb_ctrl = mem_ctrl[1:0], wb_dest = mem_dest.
REQ-025 EX/MEM and MEM/WB SHALL never stall or flush; latency ID->EX, EX->MEM, MEM->WB is 1 cycle each.
REQ-026 bubble_cnt SHALL increment by 1 on each edge where stall|branch_taken=1 and saturate at all-ones.
REQ-027 A bubble SHALL have every control bit 0, so it causes no memory access, register write, branch or jump.
REQ-028 The stall condition SHALL last at most one cycle per load, because the bubble clears ex_ctrl[7].

Reset
REQ-029 While reset=1 at an edge, all registered outputs and bubble_cnt SHALL become 0.
REQ-030 While reset=1, pc_write=0, ifid_write=0 and ifid_flush=1, regardless of other inputs.
REQ-031 Reset asserted mid-stall or mid-flush SHALL take priority; the first edge after deassertion SHALL resume normal loading of id_ctrl.

Verification
REQ-032 R-type id_ctrl=11'b10000100010, id_rd=7, no hazard -> ex_ctrl equals input after 1 edge; mem_dest=7 and mem_ctrl=4'b0001 after 2 edges; wb_ctrl=2'b01 and wb_dest=7 after 3 edges.
REQ-033 lw in EX (ex_ctrl[7]=1, ex_rt=5) and addi in ID with id_rs=5 -> stall=1, pc_write=0, ifid_write=0; next ex_ctrl=0; bubble_cnt +1; the following cycle stall=0.
REQ-034 lw in EX with ex_rt=0 and id_rs=0 -> stall=0, no bubble.
REQ-035 beq in EX with ex_zero=1 and load_use also true -> branch_taken=1, stall=0, ifid_flush=1, pc_write=1; next ex_ctrl=0.
REQ-036 Jump in ID (id_ctrl[0]=1) with no hazard -> ifid_flush=1 for one cycle. Jump in ID while stall=1 -> ifid_flush=0 that cycle and 1 the next.
REQ-037 Force bubble_cnt to all-ones via repeated stalls with CNT_W=4 -> the value holds at 4'hF; reset pulse -> all outputs 0 and pc_write=0 during reset.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch/jump flush steering and a saturating count of inserted bubbles.
module ctrl_pipe_hazard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      id_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_zero,
  output logic [10:0]      ex_ctrl,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [3:0]       mem_ctrl,
  output logic [4:0]       mem_dest,
  output logic [1:0]       wb_ctrl,
  output logic [4:0]       wb_dest,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             branch_taken,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [10:0]      ex_ctrl_q, ex_ctrl_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [3:0]       mem_ctrl_q, mem_ctrl_d;
  logic [4:0]       mem_dest_q, mem_dest_d;
  logic [1:0]       wb_ctrl_q, wb_ctrl_d;
  logic [4:0]       wb_dest_q, wb_dest_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic id_reads_rt;
  logic stall;
  logic bubble;

  always_comb begin
    branch_taken = (ex_ctrl_q[9] & ex_zero) | (ex_ctrl_q[8] & ~ex_zero);

    // rt is a source unless the ID instruction takes an immediate; stores always read rt
    id_reads_rt = ~id_ctrl[2] | id_ctrl[3];
    load_use    = ex_ctrl_q[7] & (ex_rt_q != 5'd0) &
                  ((ex_rt_q == id_rs) | ((ex_rt_q == id_rt) & id_reads_rt));

    stall  = load_use & ~branch_taken;
    bubble = stall | branch_taken;

    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = branch_taken | (id_ctrl[0] & ~stall);
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end

    ex_ctrl_d = bubble ? 11'd0 : id_ctrl;
    ex_rt_d   = bubble ? 5'd0  : id_rt;
    ex_rd_d   = bubble ? 5'd0  : id_rd;

    mem_ctrl_d = {ex_ctrl_q[7], ex_ctrl_q[3], ex_ctrl_q[6], ex_ctrl_q[1]};
    mem_dest_d = ex_ctrl_q[10] ? ex_rd_q : ex_rt_q;

    wb_ctrl_d = mem_ctrl_q[1:0];
    wb_dest_d = mem_dest_q;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q    <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      mem_ctrl_q   <= '0;
      mem_dest_q   <= '0;
      wb_ctrl_q    <= '0;
      wb_dest_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_dest_q   <= mem_dest_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_dest_q    <= wb_dest_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign mem_dest   = mem_dest_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign wb_dest    = wb_dest_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: instruction-level pipeline model checked every
// cycle, plus hand-computed checkpoints on directed hazard scenarios.
module tb_ctrl_pipe_hazard;

  localparam int CNT_W = 4;

  localparam logic [10:0] R_T    = 11'b10000100010;
  localparam logic [10:0] LW     = 11'b00011000110;
  localparam logic [10:0] ADDI   = 11'b00000000110;
  localparam logic [10:0] SW     = 11'b00000001100;
  localparam logic [10:0] BEQ_LD = 11'b01010010000;
  localparam logic [10:0] BNE    = 11'b00100010000;
  localparam logic [10:0] JMP    = 11'b00000000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [10:0]      id_ctrl = '0;
  logic [4:0]       id_rs = '0, id_rt = '0, id_rd = '0;
  logic             ex_zero = 1'b0;
  logic [10:0]      ex_ctrl;
  logic [4:0]       ex_rt, ex_rd, mem_dest, wb_dest;
  logic [3:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic             pc_write, ifid_write, ifid_flush, branch_taken;
  logic [CNT_W-1:0] bubble_cnt;

  ctrl_pipe_hazard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_ctrl(ex_ctrl), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_dest(mem_dest), .wb_ctrl(wb_ctrl),
    .wb_dest(wb_dest), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .branch_taken(branch_taken), .bubble_cnt(bubble_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic [10:0] ctrl;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;
  typedef struct packed {
    logic       reads_mem;
    logic       writes_mem;
    logic       mem_to_reg;
    logic       writes_reg;
    logic [4:0] dest;
  } mem_t;
  typedef struct packed {
    logic       mem_to_reg;
    logic       writes_reg;
    logic [4:0] dest;
  } wb_t;

  ex_t  m_ex  = '0;
  mem_t m_mem = '0;
  wb_t  m_wb  = '0;
  int   m_bubbles = 0;
  bit   m_live = 1'b0;

  function automatic bit m_taken();
    bit is_beq = m_ex.ctrl[9];
    bit is_bne = m_ex.ctrl[8];
    return (is_beq && ex_zero) || (is_bne && !ex_zero);
  endfunction

  function automatic bit m_stall();
    bit is_load = m_ex.ctrl[7];
    bit uses_rt = !id_ctrl[2] || id_ctrl[3];
    bit hazard;
    hazard = is_load && m_ex.rt != 0 &&
             (m_ex.rt == id_rs || (m_ex.rt == id_rt && uses_rt));
    return hazard && !m_taken();
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_bubbles <= 0; m_live <= 1'b1;
    end else begin
      m_wb  <= '{mem_to_reg: m_mem.mem_to_reg, writes_reg: m_mem.writes_reg, dest: m_mem.dest};
      m_mem <= '{reads_mem: m_ex.ctrl[7], writes_mem: m_ex.ctrl[3],
                 mem_to_reg: m_ex.ctrl[6], writes_reg: m_ex.ctrl[1],
                 dest: (m_ex.ctrl[10] ? m_ex.rd : m_ex.rt)};
      if (m_stall() || m_taken()) begin
        m_ex <= '0;
        m_bubbles <= m_bubbles + 1;
      end else begin
        m_ex <= '{ctrl: id_ctrl, rt: id_rt, rd: id_rd};
      end
    end
  end

  // Compare process: every cycle once the first reset edge has defined state.
  always @(negedge clk) begin
    if (m_live) begin
      int exp_cnt;
      exp_cnt = (m_bubbles > 15) ? 15 : m_bubbles;
      chk("ex_ctrl",  16'(ex_ctrl),  16'(m_ex.ctrl));
      chk("ex_rt",    16'(ex_rt),    16'(m_ex.rt));
      chk("ex_rd",    16'(ex_rd),    16'(m_ex.rd));
      chk("mem_ctrl", 16'(mem_ctrl),
          16'({m_mem.reads_mem, m_mem.writes_mem, m_mem.mem_to_reg, m_mem.writes_reg}));
      chk("mem_dest", 16'(mem_dest), 16'(m_mem.dest));
      chk("wb_ctrl",  16'(wb_ctrl),  16'({m_wb.mem_to_reg, m_wb.writes_reg}));
      chk("wb_dest",  16'(wb_dest),  16'(m_wb.dest));
      chk("bubble_cnt", 16'(bubble_cnt), 16'(exp_cnt));
      chk("branch_taken", 16'(branch_taken), 16'(m_taken()));
      chk("pc_write",   16'(pc_write),   16'(!reset && !m_stall()));
      chk("ifid_write", 16'(ifid_write), 16'(!reset && !m_stall()));
      chk("ifid_flush", 16'(ifid_flush),
          16'(reset || m_taken() || (id_ctrl[0] && !m_stall())));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic z);
    id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    tick();
    chk("rst_pc_write", 16'(pc_write), 16'h0);
    chk("rst_ifid_flush", 16'(ifid_flush), 16'h1);
    chk("rst_ex_ctrl", 16'(ex_ctrl), 16'h0);
    tick();
    reset = 1'b0;

    // R-type flowing through the three stages
    set_in(R_T, 5'd1, 5'd2, 5'd7, 1'b0);
    tick();
    chk("r_ex_ctrl", 16'(ex_ctrl), 16'h0422);
    set_in(11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("r_mem_dest", 16'(mem_dest), 16'd7);
    chk("r_mem_ctrl", 16'(mem_ctrl), 16'h1);
    tick();
    chk("r_wb_ctrl", 16'(wb_ctrl), 16'h1);
    chk("r_wb_dest", 16'(wb_dest), 16'd7);

    // Load-use on rs
    set_in(LW, 5'd3, 5'd5, 5'd0, 1'b0);
    tick();
    set_in(ADDI, 5'd5, 5'd6, 5'd0, 1'b0);
    chk("lu_pc_write", 16'(pc_write), 16'h0);
    chk("lu_ifid_write", 16'(ifid_write), 16'h0);
    tick();
    chk("lu_bubble", 16'(ex_ctrl), 16'h0);
    chk("lu_cnt", 16'(bubble_cnt), 16'd1);
    chk("lu_mem_ctrl", 16'(mem_ctrl), 16'hB);
    chk("lu_mem_dest", 16'(mem_dest), 16'd5);
    chk("lu_resume", 16'(pc_write), 16'h1);
    tick();
    chk("lu_addi_ex", 16'(ex_ctrl), 16'(ADDI));

    // Load to r0 never stalls; immediate-form rt match never stalls
    set_in(LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    set_in(ADDI, 5'd0, 5'd4, 5'd0, 1'b0);
    chk("r0_no_stall", 16'(pc_write), 16'h1);
    tick();
    set_in(LW, 5'd1, 5'd6, 5'd0, 1'b0);
    tick();
    set_in(ADDI, 5'd2, 5'd6, 5'd0, 1'b0);
    chk("imm_rt_no_stall", 16'(pc_write), 16'h1);
    tick();
    chk("r0_cnt", 16'(bubble_cnt), 16'd1);

    // Taken branch outranks a simultaneous load-use
    set_in(BEQ_LD, 5'd0, 5'd8, 5'd0, 1'b0);
    tick();
    set_in(ADDI, 5'd8, 5'd1, 5'd0, 1'b1);
    chk("br_taken", 16'(branch_taken), 16'h1);
    chk("br_pc_write", 16'(pc_write), 16'h1);
    chk("br_flush", 16'(ifid_flush), 16'h1);
    tick();
    chk("br_bubble", 16'(ex_ctrl), 16'h0);
    chk("br_cnt", 16'(bubble_cnt), 16'd2);

    // bne taken on zero=0, not taken on zero=1
    set_in(BNE, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    set_in(11'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("bne_not_taken", 16'(branch_taken), 16'h0);
    set_in(11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("bne_taken", 16'(branch_taken), 16'h1);
    tick();
    chk("bne_cnt", 16'(bubble_cnt), 16'd3);

    // Jump without and with a concurrent stall
    set_in(JMP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("j_flush", 16'(ifid_flush), 16'h1);
    tick();
    set_in(11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("j_flush_once", 16'(ifid_flush), 16'h0);
    set_in(LW, 5'd0, 5'd9, 5'd0, 1'b0);
    tick();
    set_in(JMP, 5'd9, 5'd0, 5'd0, 1'b0);
    chk("js_no_flush", 16'(ifid_flush), 16'h0);
    tick();
    chk("js_flush_next", 16'(ifid_flush), 16'h1);
    chk("js_cnt", 16'(bubble_cnt), 16'd4);
    tick();
    chk("js_ex_ctrl", 16'(ex_ctrl), 16'(JMP));

    // Saturate the counter; alternate rs-use and store-rt-use hazards
    for (int i = 0; i < 14; i++) begin
      set_in(LW, 5'd0, 5'd5, 5'd0, 1'b0);
      tick();
      if (i % 2 == 0) set_in(ADDI, 5'd5, 5'd1, 5'd0, 1'b0);
      else            set_in(SW, 5'd0, 5'd5, 5'd0, 1'b0);
      tick();
    end
    chk("sat_cnt", 16'(bubble_cnt), 16'hF);

    // Reset in the middle of a stall
    set_in(LW, 5'd0, 5'd5, 5'd0, 1'b0);
    tick();
    set_in(ADDI, 5'd5, 5'd0, 5'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_pc_write", 16'(pc_write), 16'h0);
    chk("mr_ifid_write", 16'(ifid_write), 16'h0);
    chk("mr_flush", 16'(ifid_flush), 16'h1);
    tick();
    chk("mr_ex_ctrl", 16'(ex_ctrl), 16'h0);
    chk("mr_mem_ctrl", 16'(mem_ctrl), 16'h0);
    chk("mr_cnt", 16'(bubble_cnt), 16'h0);
    reset = 1'b0;
    #1;
    tick();
    chk("mr_resume", 16'(ex_ctrl), 16'(ADDI));
    set_in(11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
